// File: rtl/if_id_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary of the RV32I core.
package pipeline_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- the canonical RV32I no-op
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction as it travels from fetch to decode.
    // Field order (instr in the MSBs) matches the flat word used by the queue storage.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_entry_t;

endpackage : pipeline_pkg

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID queue.
interface if_id_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // fetch side
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] PC_F_i;
    logic [DATA_WIDTH-1:0] Instr_i;
    logic [DATA_WIDTH-1:0] PCPlus4F_i;

    // pipeline control
    logic                  flush_i;
    logic                  stall_i;

    // decode side
    logic                  valid_D_o;
    logic [DATA_WIDTH-1:0] Instr_D_o;
    logic [DATA_WIDTH-1:0] PC_D_o;
    logic [DATA_WIDTH-1:0] PCPlus4D_o;
    logic [CNT_W-1:0]      count_o;

    // Producer of fetch traffic and control (fetch stage / hazard unit)
    modport master (
        output valid_i, PC_F_i, Instr_i, PCPlus4F_i, flush_i, stall_i,
        input  ready_o, valid_D_o, Instr_D_o, PC_D_o, PCPlus4D_o, count_o
    );

    // The queue itself
    modport slave (
        input  valid_i, PC_F_i, Instr_i, PCPlus4F_i, flush_i, stall_i,
        output ready_o, valid_D_o, Instr_D_o, PC_D_o, PCPlus4D_o, count_o
    );

endinterface : if_id_queue_if

// File: rtl/if_id_queue_mem.sv
// DEPTH-entry storage for the IF/ID queue: one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset; the
// occupancy logic in the parent decides whether a slot is meaningful.
module if_id_queue_mem #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted fetch entry into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head entry is read combinationally so it is visible right after the push edge
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: lets fetch run ahead of a stalled decode for up to
// DEPTH instructions and drops every queued wrong-path instruction on a
// taken branch/jump resolved in Execute.
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 3 * DATA_WIDTH;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] wdata_s;
    logic [ENTRY_W-1:0] rdata_s;

    // Occupancy flags and handshake qualifiers; ready/valid depend only on registered count
    always_comb begin
        full_s  = (count_q == CNT_W'(DEPTH));
        empty_s = (count_q == {CNT_W{1'b0}});
        push_s  = bus.valid_i & ~full_s & ~bus.flush_i;
        pop_s   = ~empty_s & ~bus.stall_i & ~bus.flush_i;
    end

    // Next-state for pointers and occupancy; a flush empties the queue by snapping read to write
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pack the fetch fields in the same order as if_id_entry_t
    always_comb begin
        wdata_s = {bus.Instr_i, bus.PC_F_i, bus.PCPlus4F_i};
    end

    if_id_queue_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Decode-side outputs: head entry when occupied, NOP/0/0 bubble when empty
    always_comb begin
        bus.ready_o   = ~full_s;
        bus.valid_D_o = ~empty_s;
        bus.count_o   = count_q;
        if (empty_s) begin
            bus.Instr_D_o  = DATA_WIDTH'(NOP_INSTR);
            bus.PC_D_o     = {DATA_WIDTH{1'b0}};
            bus.PCPlus4D_o = {DATA_WIDTH{1'b0}};
        end else begin
            bus.Instr_D_o  = rdata_s[3*DATA_WIDTH-1:2*DATA_WIDTH];
            bus.PC_D_o     = rdata_s[2*DATA_WIDTH-1:DATA_WIDTH];
            bus.PCPlus4D_o = rdata_s[DATA_WIDTH-1:0];
        end
    end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_if_id_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ent_t        mq[$];
    logic        m_push;
    logic        m_pop;
    logic [31:0] pre_pc;

    if_id_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    if_id_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic e_valid();
        return mq.size() != 0;
    endfunction
    function automatic logic [31:0] e_instr();
        return (mq.size() != 0) ? mq[0].instr : NOP;
    endfunction
    function automatic logic [31:0] e_pc();
        return (mq.size() != 0) ? mq[0].pc : 32'h0;
    endfunction
    function automatic logic [31:0] e_pp4();
        return (mq.size() != 0) ? mq[0].pp4 : 32'h0;
    endfunction

    // Drive one cycle of inputs, advance the clock, update the reference model
    task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic fl, input logic st, input logic r);
        ent_t e;
        e.pc = pc; e.instr = instr; e.pp4 = pc + 32'd4;
        bus.valid_i = v; bus.PC_F_i = pc; bus.Instr_i = instr; bus.PCPlus4F_i = e.pp4;
        bus.flush_i = fl; bus.stall_i = st; rst = r;
        m_push = v && (mq.size() < DEPTH) && !fl;
        m_pop  = (mq.size() != 0) && !st && !fl;
        pre_pc = bus.PC_D_o;
        @(posedge clk);
        #1;
        if (r || fl) begin
            mq.delete();
        end else begin
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.valid_D_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_D_o); end
        checks++; if (bus.Instr_D_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", bus.Instr_D_o, NOP); end
        checks++; if (bus.PC_D_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.PC_D_o); end
        checks++; if (bus.PCPlus4D_o !== 32'h0) begin errors++; $display("FAIL reset_pp4: got %h want 0", bus.PCPlus4D_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    endtask

    task automatic test_single_push();
        tick(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.valid_D_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.valid_D_o); end
        checks++; if (bus.Instr_D_o !== 32'h0050_0093) begin errors++; $display("FAIL single_instr: got %h want 00500093", bus.Instr_D_o); end
        checks++; if (bus.PC_D_o !== 32'h0) begin errors++; $display("FAIL single_pc: got %h want 0", bus.PC_D_o); end
        checks++; if (bus.PCPlus4D_o !== 32'h4) begin errors++; $display("FAIL single_pp4: got %h want 4", bus.PCPlus4D_o); end
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.valid_D_o !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", bus.valid_D_o); end
        checks++; if (bus.Instr_D_o !== NOP) begin errors++; $display("FAIL single_pop_instr: got %h want %h", bus.Instr_D_o, NOP); end
    endtask

    task automatic test_stall_fill();
        logic [1:0] exp_cnt [3] = '{2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0);
            checks++; if (bus.count_o !== exp_cnt[i]) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count_o, exp_cnt[i]); end
            checks++; if (bus.PC_D_o !== 32'h0) begin errors++; $display("FAIL fill_head[%0d]: got %h want 0", i, bus.PC_D_o); end
        end
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", bus.ready_o); end
    endtask

    // Queue is FULL with PC 0x0,0x4; release stall with fetch pushing continuously
    task automatic test_drain_wrap();
        logic [31:0] next_pc = 32'h8;
        logic [31:0] seen[$];
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL drain_ready_same_cycle: got %b want 0", bus.ready_o); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, next_pc, $urandom, 1'b0, 1'b0, 1'b0);
            if (m_pop)  seen.push_back(pre_pc);
            if (m_push) next_pc = next_pc + 32'd4;
            if (i == 0) begin
                checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready_next: got %b want 1", bus.ready_o); end
                checks++; if (bus.count_o !== 2'd1) begin errors++; $display("FAIL drain_count_next: got %0d want 1", bus.count_o); end
            end
        end
        checks++; if (seen.size() !== 8) begin errors++; $display("FAIL drain_pop_count: got %0d want 8", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            checks++; if (seen[i] !== 32'(4 * i)) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, seen[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_flush();
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 32'h10, $urandom, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 32'h14, $urandom, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.count_o !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d want 2", bus.count_o); end
        tick(1'b1, 32'h18, $urandom, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.valid_D_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.valid_D_o); end
        checks++; if (bus.Instr_D_o !== NOP) begin errors++; $display("FAIL flush_instr: got %h want %h", bus.Instr_D_o, NOP); end
        tick(1'b1, 32'h40, 32'h0010_0113, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.PC_D_o !== 32'h40) begin errors++; $display("FAIL flush_refill_pc: got %h want 40", bus.PC_D_o); end
        checks++; if (bus.Instr_D_o !== 32'h0010_0113) begin errors++; $display("FAIL flush_refill_instr: got %h want 00100113", bus.Instr_D_o); end
        checks++; if (bus.count_o !== 2'd1) begin errors++; $display("FAIL flush_refill_count: got %0d want 1", bus.count_o); end
    endtask

    task automatic test_reset_midstream();
        tick(1'b1, 32'h20, $urandom, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.count_o !== 2'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 2", bus.count_o); end
        tick(1'b1, 32'h24, $urandom, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.valid_D_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.valid_D_o); end
        checks++; if (bus.Instr_D_o !== NOP) begin errors++; $display("FAIL rstmid_instr: got %h want %h", bus.Instr_D_o, NOP); end
        checks++; if (bus.PC_D_o !== 32'h0) begin errors++; $display("FAIL rstmid_pc: got %h want 0", bus.PC_D_o); end
        checks++; if (bus.PCPlus4D_o !== 32'h0) begin errors++; $display("FAIL rstmid_pp4: got %h want 0", bus.PCPlus4D_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.ready_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 59) == 0));
            checks++; if (bus.count_o !== 2'(mq.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d want %0d", i, bus.count_o, mq.size()); end
            checks++; if (bus.ready_o !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_ready@%0d: got %b", i, bus.ready_o); end
            checks++; if (bus.valid_D_o !== e_valid()) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", i, bus.valid_D_o, e_valid()); end
            checks++; if (bus.Instr_D_o !== e_instr()) begin errors++; $display("FAIL rand_instr@%0d: got %h want %h", i, bus.Instr_D_o, e_instr()); end
            checks++; if (bus.PC_D_o !== e_pc()) begin errors++; $display("FAIL rand_pc@%0d: got %h want %h", i, bus.PC_D_o, e_pc()); end
            checks++; if (bus.PCPlus4D_o !== e_pp4()) begin errors++; $display("FAIL rand_pp4@%0d: got %h want %h", i, bus.PCPlus4D_o, e_pp4()); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.PC_F_i = '0; bus.Instr_i = '0; bus.PCPlus4F_i = '0;
        bus.flush_i = 1'b0; bus.stall_i = 1'b0;
        test_reset();
        test_single_push();
        test_stall_fill();
        test_drain_wrap();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_id_queue
